// File: rtl/pb_rtc_bus_writer.sv
// pb_rtc_bus_writer: PicoBlaze output-side peripheral that stages an RTC
// register address and write data from PicoBlaze port writes, then runs a
// timed write cycle on the RTC multiplexed address/data bus.
// The cycle is address assert, address release (hold), data assert, data
// release (hold), then return to idle with a one-cycle done pulse.
// Optional feature: define PB_RTC_WR_IRQ_EN to add a sticky completion
// interrupt with an acknowledge input.
module pb_rtc_bus_writer #(
    parameter logic [7:0] ADDR_PORT = 8'h01,
    parameter logic [7:0] DATA_PORT = 8'h02,
    parameter logic [7:0] CMD_PORT  = 8'h03,
    parameter int         T_PHASE   = 10,
    parameter int         CNT_W     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] port_id,
    input  logic [7:0] out_port,
    input  logic       write_strobe,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       a_d,
    output logic       cs_n,
    output logic       wr_n,
    output logic       rd_n,
    output logic [7:0] status,
    output logic       done
`ifdef PB_RTC_WR_IRQ_EN
    ,
    output logic       interrupt,
    input  logic       interrupt_ack
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR_ASSERT,
        S_ADDR_RELEASE,
        S_DATA_ASSERT,
        S_DATA_RELEASE
    } state_t;

    // Each sub-phase lasts T_PHASE cycles: the counter loads T_PHASE-1 on
    // state entry and the state advances on the cycle it reads zero.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(T_PHASE - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_addr_stg;
    logic [7:0]       r_data_stg;
    logic [7:0]       r_addr_sh;
    logic [7:0]       r_data_sh;
    logic             r_busy;
    logic             r_overrun;
    logic             r_done;
    logic [7:0]       r_ad_out;
    logic             r_ad_oe;
    logic             r_a_d;
    logic             r_cs_n;
    logic             r_wr_n;

    logic w_wr_addr;
    logic w_wr_data;
    logic w_wr_cmd;
    logic w_phase_end;
    logic w_complete;

    assign w_wr_addr   = write_strobe && (port_id == ADDR_PORT);
    assign w_wr_data   = write_strobe && (port_id == DATA_PORT);
    assign w_wr_cmd    = write_strobe && (port_id == CMD_PORT);
    assign w_phase_end = (r_cnt == '0);
    assign w_complete  = (r_state == S_DATA_RELEASE) && w_phase_end;

    // Staging registers: load from PicoBlaze writes at any time, even mid-cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr_stg <= 8'h00;
            r_data_stg <= 8'h00;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block ordering.
            if (w_wr_addr) r_addr_stg <= out_port;
            if (w_wr_data) r_data_stg <= out_port;
        end
    end

    // Bus-cycle FSM with registered bus pins, busy/overrun status and done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_addr_sh <= 8'h00;
            r_data_sh <= 8'h00;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
            r_done    <= 1'b0;
            r_ad_out  <= 8'h00;
            r_ad_oe   <= 1'b0;
            r_a_d     <= 1'b0;
            r_cs_n    <= 1'b1;
            r_wr_n    <= 1'b1;
        end else begin
            r_done <= 1'b0;

            // A start while busy sets overrun and takes priority over clear.
            if (w_wr_cmd) begin
                if (out_port[0] && (r_state != S_IDLE)) begin
                    r_overrun <= 1'b1;
                end else if (out_port[1]) begin
                    r_overrun <= 1'b0;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (w_wr_cmd && out_port[0]) begin
                        r_addr_sh <= r_addr_stg;
                        r_data_sh <= r_data_stg;
                        r_state   <= S_ADDR_ASSERT;
                        r_cnt     <= CNT_LOAD;
                        r_busy    <= 1'b1;
                        r_ad_out  <= r_addr_stg;
                        r_ad_oe   <= 1'b1;
                        r_a_d     <= 1'b0;
                        r_cs_n    <= 1'b0;
                        r_wr_n    <= 1'b0;
                    end
                end
                S_ADDR_ASSERT: begin
                    if (w_phase_end) begin
                        r_state <= S_ADDR_RELEASE;
                        r_cnt   <= CNT_LOAD;
                        r_cs_n  <= 1'b1;
                        r_wr_n  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_ADDR_RELEASE: begin
                    if (w_phase_end) begin
                        r_state  <= S_DATA_ASSERT;
                        r_cnt    <= CNT_LOAD;
                        r_ad_out <= r_data_sh;
                        r_a_d    <= 1'b1;
                        r_cs_n   <= 1'b0;
                        r_wr_n   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DATA_ASSERT: begin
                    if (w_phase_end) begin
                        r_state <= S_DATA_RELEASE;
                        r_cnt   <= CNT_LOAD;
                        r_cs_n  <= 1'b1;
                        r_wr_n  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DATA_RELEASE: begin
                    if (w_phase_end) begin
                        r_state  <= S_IDLE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_ad_out <= 8'h00;
                        r_ad_oe  <= 1'b0;
                        r_a_d    <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef PB_RTC_WR_IRQ_EN
    logic r_interrupt;

    // Sticky completion interrupt; a completion in the ack cycle keeps it set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_interrupt <= 1'b0;
        end else if (w_complete) begin
            r_interrupt <= 1'b1;
        end else if (interrupt_ack) begin
            r_interrupt <= 1'b0;
        end
    end

    assign interrupt = r_interrupt;
`endif

    assign ad_out = r_ad_out;
    assign ad_oe  = r_ad_oe;
    assign a_d    = r_a_d;
    assign cs_n   = r_cs_n;
    assign wr_n   = r_wr_n;
    assign rd_n   = 1'b1;
    assign status = {6'b000000, r_overrun, r_busy};
    assign done   = r_done;

endmodule

// File: tb/tb_pb_rtc_bus_writer.sv
// Self-checking bench for pb_rtc_bus_writer: cycle-by-cycle model of the bus
// pins plus a scoreboard of expected {address, data} pairs per bus cycle.
module tb_pb_rtc_bus_writer;

    localparam int         T      = 10;
    localparam logic [7:0] ADDR_P = 8'h01;
    localparam logic [7:0] DATA_P = 8'h02;
    localparam logic [7:0] CMD_P  = 8'h03;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] port_id;
    logic [7:0] out_port;
    logic       write_strobe;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic       a_d;
    logic       cs_n;
    logic       wr_n;
    logic       rd_n;
    logic [7:0] status;
    logic       done;
`ifdef PB_RTC_WR_IRQ_EN
    logic       interrupt;
    logic       interrupt_ack;
`endif

    pb_rtc_bus_writer #(
        .ADDR_PORT(ADDR_P),
        .DATA_PORT(DATA_P),
        .CMD_PORT (CMD_P),
        .T_PHASE  (T),
        .CNT_W    (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .port_id     (port_id),
        .out_port    (out_port),
        .write_strobe(write_strobe),
        .ad_out      (ad_out),
        .ad_oe       (ad_oe),
        .a_d         (a_d),
        .cs_n        (cs_n),
        .wr_n        (wr_n),
        .rd_n        (rd_n),
        .status      (status),
        .done        (done)
`ifdef PB_RTC_WR_IRQ_EN
        ,
        .interrupt    (interrupt),
        .interrupt_ack(interrupt_ack)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } xfer_t;

    xfer_t sb_q[$];
    xfer_t mon_e;
    int    n_checks = 0;
    int    n_errors = 0;

    // Reference model state
    logic [7:0] m_addr_stg = 8'h00;
    logic [7:0] m_data_stg = 8'h00;
    logic [7:0] m_addr_sh  = 8'h00;
    logic [7:0] m_data_sh  = 8'h00;
    bit         m_overrun  = 1'b0;

    // Write currently on the PicoBlaze bus, applied to the model once sampled
    bit         pend      = 1'b0;
    bit         pend_busy = 1'b0;
    logic [7:0] pend_port = 8'h00;
    logic [7:0] pend_val  = 8'h00;

    // Monitor capture of what the bus actually carried
    logic [7:0] cap_a = 8'h00;
    logic [7:0] cap_d = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_now(input logic [7:0] p, input logic [7:0] v, input bit busy_now);
        port_id      = p;
        out_port     = v;
        write_strobe = 1'b1;
        pend         = 1'b1;
        pend_port    = p;
        pend_val     = v;
        pend_busy    = busy_now;
        if (p == CMD_P && v[0] && !busy_now) begin
            m_addr_sh = m_addr_stg;
            m_data_sh = m_data_stg;
            sb_q.push_back('{addr: m_addr_stg, data: m_data_stg});
        end
    endtask

    task automatic release_pending();
        if (pend) begin
            write_strobe = 1'b0;
            port_id      = 8'h00;
            out_port     = 8'h00;
            pend         = 1'b0;
            if (pend_port == ADDR_P) m_addr_stg = pend_val;
            else if (pend_port == DATA_P) m_data_stg = pend_val;
            else if (pend_port == CMD_P) begin
                if (pend_val[0] && pend_busy) m_overrun = 1'b1;
                else if (pend_val[1]) m_overrun = 1'b0;
            end
        end
    endtask

    task automatic stage(input logic [7:0] p, input logic [7:0] v);
        @(negedge clk);
        release_pending();
        drive_now(p, v, 1'b0);
        @(negedge clk);
        release_pending();
    endtask

    task automatic start_xfer(input logic [7:0] v);
        @(negedge clk);
        release_pending();
        drive_now(CMD_P, v, 1'b0);
    endtask

    // Follow one bus cycle from the cycle after the start edge to the done
    // cycle, optionally injecting one PicoBlaze write and/or a chained start.
    task automatic run_cycle(input int inj_c, input logic [7:0] inj_p, input logic [7:0] inj_v,
                             input bit chain);
        int phase;
        int e_busy, e_cs, e_ad, e_oe, e_done;
        for (int c = 1; c <= 4 * T + 1; c++) begin
            @(negedge clk);
            release_pending();
            if (c <= 4 * T) begin
                phase  = (c - 1) / T;
                e_busy = 1;
                e_cs   = (phase == 0 || phase == 2) ? 0 : 1;
                e_ad   = (phase >= 2) ? 1 : 0;
                e_oe   = 1;
                e_done = 0;
            end else begin
                e_busy = 0;
                e_cs   = 1;
                e_ad   = 0;
                e_oe   = 0;
                e_done = 1;
            end
            check($sformatf("c%0d cs_n", c), 32'(cs_n), e_cs);
            check($sformatf("c%0d wr_n", c), 32'(wr_n), e_cs);
            check($sformatf("c%0d a_d", c), 32'(a_d), e_ad);
            check($sformatf("c%0d ad_oe", c), 32'(ad_oe), e_oe);
            check($sformatf("c%0d done", c), 32'(done), e_done);
            check($sformatf("c%0d rd_n", c), 32'(rd_n), 1);
            check($sformatf("c%0d status", c), 32'(status), (32'(m_overrun) << 1) | e_busy);
            if (e_oe == 1)
                check($sformatf("c%0d ad_out", c), 32'(ad_out), (e_ad == 1) ? 32'(m_data_sh) : 32'(m_addr_sh));
            if (c == inj_c) drive_now(inj_p, inj_v, c <= 4 * T);
            if (chain && c == 4 * T + 1) drive_now(CMD_P, 8'h01, 1'b0);
        end
    endtask

    // Scoreboard monitor: record what the bus carried, compare on done.
    always @(negedge clk) begin
        if (rst) begin
            cap_a = 8'h00;
            cap_d = 8'h00;
        end else begin
            if (!cs_n && !a_d) cap_a = ad_out;
            if (!cs_n && a_d) cap_d = ad_out;
            if (done) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_done", 32'(done), 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("sb_addr", 32'(cap_a), 32'(mon_e.addr));
                    check("sb_data", 32'(cap_d), 32'(mon_e.data));
                end
            end
        end
    end

    initial begin
        int n_done;
        rst          = 1'b1;
        write_strobe = 1'b0;
        port_id      = 8'h00;
        out_port     = 8'h00;
`ifdef PB_RTC_WR_IRQ_EN
        interrupt_ack = 1'b0;
`endif
        #1;
        check("rst cs_n", 32'(cs_n), 1);
        check("rst wr_n", 32'(wr_n), 1);
        check("rst rd_n", 32'(rd_n), 1);
        check("rst ad_oe", 32'(ad_oe), 0);
        check("rst a_d", 32'(a_d), 0);
        check("rst ad_out", 32'(ad_out), 0);
        check("rst status", 32'(status), 0);
        check("rst done", 32'(done), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset asserted in the middle of the address phase
        stage(ADDR_P, 8'h55);
        stage(DATA_P, 8'h66);
        start_xfer(8'h01);
        @(negedge clk);
        release_pending();
        @(negedge clk);
        check("mid cs_n before reset", 32'(cs_n), 0);
        #2 rst = 1'b1;
        #1;
        check("midrst cs_n", 32'(cs_n), 1);
        check("midrst wr_n", 32'(wr_n), 1);
        check("midrst ad_oe", 32'(ad_oe), 0);
        check("midrst status", 32'(status), 0);
        check("midrst done", 32'(done), 0);
`ifdef PB_RTC_WR_IRQ_EN
        check("midrst interrupt", 32'(interrupt), 0);
`endif
        sb_q.delete();
        m_addr_stg = 8'h00;
        m_data_stg = 8'h00;
        m_overrun  = 1'b0;
        @(negedge clk);
        rst    = 1'b0;
        n_done = 0;
        for (int i = 0; i < 5 * T; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("no done after reset", 32'(n_done), 0);
        check("idle cs_n after reset", 32'(cs_n), 1);

        // Basic write cycle: address 05, data 3A
        stage(ADDR_P, 8'h05);
        stage(DATA_P, 8'h3A);
        start_xfer(8'h01);
        run_cycle(0, 8'h00, 8'h00, 1'b0);
`ifdef PB_RTC_WR_IRQ_EN
        check("irq on done", 32'(interrupt), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("irq hold %0d", i), 32'(interrupt), 1);
        end
        interrupt_ack = 1'b1;
        @(negedge clk);
        interrupt_ack = 1'b0;
        check("irq after ack", 32'(interrupt), 0);
`endif
        @(negedge clk);
        check("status after first cycle", 32'(status), 0);

        // Data staging rewritten mid-cycle must not disturb the running cycle
        start_xfer(8'h01);
        run_cycle(15, DATA_P, 8'hFF, 1'b0);

        // Start while busy sets overrun; next cycle carries the new data FF
        start_xfer(8'h01);
        run_cycle(5, CMD_P, 8'h01, 1'b0);
        @(negedge clk);
        check("overrun sticky", 32'(status), 32'h02);
        stage(CMD_P, 8'h02);
        check("overrun cleared", 32'(status), 0);

        // Clear plus overrunning start in one write: set wins; then a
        // back-to-back start on the done cycle with a stray port 07 write.
        start_xfer(8'h01);
        run_cycle(12, CMD_P, 8'h03, 1'b1);
        run_cycle(3, 8'h07, 8'hAA, 1'b0);
        @(negedge clk);
        check("overrun after set-wins", 32'(status), 32'h02);

        // Start with clear from idle: clears overrun and runs a cycle
        stage(ADDR_P, 8'hC3);
        start_xfer(8'h03);
        run_cycle(0, 8'h00, 8'h00, 1'b0);
        @(negedge clk);
        check("final status", 32'(status), 0);
        check("sb queue empty", 32'(sb_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
